// File: rtl/stat_resp_misr.sv
// Response compactor: folds 32-bit benchmark output vectors into a MISR and hands off the
// final signature over valid/ready. Optional golden compare enabled by STAT_MISR_GOLDEN_CMP_EN.
module stat_resp_misr #(
  parameter int unsigned       WIDTH = 32,
  parameter logic [WIDTH-1:0]  POLY  = 32'h04C1_1DB7,
  parameter logic [WIDTH-1:0]  SEED  = 32'h0000_0000,
  parameter int unsigned       CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] pattern_count_i,
  input  logic             resp_valid_i,
  output logic             resp_ready_o,
  input  logic [WIDTH-1:0] resp_data_i,
  output logic             sig_valid_o,
  input  logic             sig_ready_i,
  output logic [WIDTH-1:0] signature_o,
  output logic [CNT_W-1:0] beats_done_o,
  output logic             busy_o
`ifdef STAT_MISR_GOLDEN_CMP_EN
  ,
  input  logic [WIDTH-1:0] golden_i,
  output logic             pass_o
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sig_q, sig_d;
  logic [CNT_W-1:0]   beats_q, beats_d;
  logic [CNT_W-1:0]   target_q, target_d;
  logic [CNT_W-1:0]   beats_inc;
  logic [WIDTH-1:0]   sig_step;

  assign beats_inc = beats_q + CNT_W'(1);
  assign sig_step  = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ resp_data_i;

  always_comb begin
    state_d  = state_q;
    sig_d    = sig_q;
    beats_d  = beats_q;
    target_d = target_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          sig_d    = SEED;
          beats_d  = '0;
          target_d = pattern_count_i;
          state_d  = (pattern_count_i == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        // resp_ready is high throughout RUN, so a valid beat is an accepted beat
        if (resp_valid_i) begin
          sig_d   = sig_step;
          beats_d = beats_inc;
          if (beats_inc == target_q) state_d = StDone;
        end
      end
      StDone: begin
        if (sig_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      sig_q    <= SEED;
      beats_q  <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      beats_q  <= beats_d;
      target_q <= target_d;
    end
  end

  assign resp_ready_o = (state_q == StRun);
  assign sig_valid_o  = (state_q == StDone);
  assign busy_o       = (state_q != StIdle);
  assign signature_o  = sig_q;
  assign beats_done_o = beats_q;

`ifdef STAT_MISR_GOLDEN_CMP_EN
  logic pass_q, pass_d;

  // Compare once on DONE entry against the signature being committed; hold through DONE.
  always_comb begin
    pass_d = 1'b0;
    if (state_d == StDone) begin
      pass_d = (state_q == StDone) ? pass_q : (sig_d == golden_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pass_q <= 1'b0;
    else       pass_q <= pass_d;
  end

  assign pass_o = pass_q;
`endif

endmodule

// File: tb/tb_stat_resp_misr.sv
// Scoreboard bench for stat_resp_misr: stimulus pushes expected signatures, a negedge monitor
// pops and compares them at each signature handshake.
module tb_stat_resp_misr;

  localparam logic [31:0] POLY = 32'h04C1_1DB7;
  localparam logic [31:0] SEED = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [15:0] pattern_count_i = '0;
  logic        resp_valid_i = 1'b0;
  logic        resp_ready_o;
  logic [31:0] resp_data_i = '0;
  logic        sig_valid_o;
  logic        sig_ready_i = 1'b0;
  logic [31:0] signature_o;
  logic [15:0] beats_done_o;
  logic        busy_o;
`ifdef STAT_MISR_GOLDEN_CMP_EN
  logic [31:0] golden_i = '0;
  logic        pass_o;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  logic [31:0] exp_q[$];
  logic        stim_done = 1'b0;

  stat_resp_misr dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .pattern_count_i (pattern_count_i),
    .resp_valid_i    (resp_valid_i),
    .resp_ready_o    (resp_ready_o),
    .resp_data_i     (resp_data_i),
    .sig_valid_o     (sig_valid_o),
    .sig_ready_i     (sig_ready_i),
    .signature_o     (signature_o),
    .beats_done_o    (beats_done_o),
    .busy_o          (busy_o)
`ifdef STAT_MISR_GOLDEN_CMP_EN
    ,
    .golden_i        (golden_i),
    .pass_o          (pass_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_start(input logic [15:0] cnt);
    start_i         = 1'b1;
    pattern_count_i = cnt;
    tick();
    start_i         = 1'b0;
    pattern_count_i = 16'hFFFF;  // later changes must be ignored
  endtask

  task automatic send_beat(input logic [31:0] data);
    int n = 0;
    while (!resp_ready_o && n < 20) begin
      tick();
      n++;
    end
    if (!resp_ready_o) check("beat_ready_timeout", 32'(resp_ready_o), 32'd1);
    resp_valid_i = 1'b1;
    resp_data_i  = data;
    tick();
    resp_valid_i = 1'b0;
    resp_data_i  = 32'hDEAD_BEEF;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!sig_valid_o && n < 20) begin
      tick();
      n++;
    end
    if (!sig_valid_o) check("done_timeout", 32'(sig_valid_o), 32'd1);
  endtask

  task automatic handshake(input logic [31:0] exp);
    exp_q.push_back(exp);
    sig_ready_i = 1'b1;
    tick();
    sig_ready_i = 1'b0;
    check("post_hs_sig_valid", 32'(sig_valid_o), 32'd0);
    check("post_hs_busy", 32'(busy_o), 32'd0);
  endtask

  // Monitor: compare signature at every handshake against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk_i);
      if (sig_valid_o && sig_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_sig", signature_o, 32'hxxxx_xxxx);
        end else begin
          check("sb_signature", signature_o, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    tick();
    tick();
    rst_i = 1'b0;
    check("rst_signature", signature_o, SEED);
    check("rst_beats", 32'(beats_done_o), 32'd0);
    check("rst_resp_ready", 32'(resp_ready_o), 32'd0);
    check("rst_sig_valid", 32'(sig_valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);

    // T1: reset mid-RUN after 3 beats of 1 -> 1, 3, 7
    do_start(16'd10);
    check("t1_busy", 32'(busy_o), 32'd1);
    send_beat(32'h1);
    send_beat(32'h1);
    send_beat(32'h1);
    check("t1_partial_sig", signature_o, 32'h7);
    check("t1_partial_beats", 32'(beats_done_o), 32'd3);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("t1_signature", signature_o, SEED);
    check("t1_beats", 32'(beats_done_o), 32'd0);
    check("t1_resp_ready", 32'(resp_ready_o), 32'd0);
    check("t1_sig_valid", 32'(sig_valid_o), 32'd0);
    check("t1_busy", 32'(busy_o), 32'd0);

    // T2: single beat
    do_start(16'd1);
    send_beat(32'h0000_0001);
    check("t2_sig_valid", 32'(sig_valid_o), 32'd1);
    check("t2_signature", signature_o, 32'h0000_0001);
    check("t2_beats", 32'(beats_done_o), 32'd1);
    check("t2_resp_ready", 32'(resp_ready_o), 32'd0);
    handshake(32'h0000_0001);

    // T3: MSB feedback
    do_start(16'd2);
    send_beat(32'h8000_0000);
    check("t3_mid_sig", signature_o, 32'h8000_0000);
    check("t3_mid_valid", 32'(sig_valid_o), 32'd0);
    send_beat(32'h0000_0000);
    check("t3_sig_valid", 32'(sig_valid_o), 32'd1);
    handshake(POLY);

    // T4: zero count goes straight to DONE
    do_start(16'd0);
    check("t4_sig_valid", 32'(sig_valid_o), 32'd1);
    check("t4_resp_ready", 32'(resp_ready_o), 32'd0);
    check("t4_signature", signature_o, SEED);
    check("t4_beats", 32'(beats_done_o), 32'd0);
    handshake(SEED);

    // T5: bubbles and backpressure; 0 -> 80000000 -> 04C11DB6 -> 09823B6C
    do_start(16'd3);
    send_beat(32'h8000_0000);
    tick();
    tick();
    check("t5_bubble_beats", 32'(beats_done_o), 32'd1);
    check("t5_bubble_sig", signature_o, 32'h8000_0000);
    send_beat(32'h0000_0001);
    tick();
    check("t5_bubble2_sig", signature_o, 32'h04C1_1DB6);
    send_beat(32'h0000_0000);
    wait_done();
    for (int i = 0; i < 5; i++) begin
      start_i = (i == 0);  // start in DONE must be ignored
      check("t5_hold_valid", 32'(sig_valid_o), 32'd1);
      check("t5_hold_sig", signature_o, 32'h0982_3B6C);
      tick();
    end
    start_i = 1'b0;
    check("t5_after_start_valid", 32'(sig_valid_o), 32'd1);
    handshake(32'h0982_3B6C);

`ifdef STAT_MISR_GOLDEN_CMP_EN
    // T6: golden compare
    golden_i = POLY;
    do_start(16'd2);
    check("t6_pass_run", 32'(pass_o), 32'd0);
    send_beat(32'h8000_0000);
    send_beat(32'h0000_0000);
    check("t6_pass_match", 32'(pass_o), 32'd1);
    handshake(POLY);
    check("t6_pass_idle", 32'(pass_o), 32'd0);
    golden_i = 32'h0;
    do_start(16'd2);
    send_beat(32'h8000_0000);
    send_beat(32'h0000_0000);
    check("t6_sig_valid", 32'(sig_valid_o), 32'd1);
    check("t6_pass_mismatch", 32'(pass_o), 32'd0);
    handshake(POLY);
`endif

    tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    stim_done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #20000;
    if (!stim_done) begin
      $display("FAIL global_timeout: stimulus did not complete");
      $fatal(1);
    end
  end

endmodule
